circle_engine: RTL and testbench

- Downstream consumer of the graphics processor's circle interface (CE_*).
- Latches a 24-bit colour and one packed argument word: centre x, centre y and radius.
- Rasterises the circle outline with the integer midpoint algorithm and writes each pixel into the frame buffer in DRAM through the request controller's address/write-data FIFOs.
- Sits beside the line engine and frame filler and shares the same DRAM request path through the arbiter.

---
 rtl/gp_pkg.sv | 49 ++++
 rtl/circle_engine_pixel_burst_writer.sv | 74 +++++++
 rtl/circle_engine.sv | 169 ++++++++++++++++
 tb/tb_circle_engine.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gp_pkg.sv
// Shared definitions for the graphics-processor drawing engines:
// state encodings, screen size, argument field positions, DRAM slices.
package gp_pkg;

  localparam int GP_SCREEN_W = 800;
  localparam int GP_SCREEN_H = 600;
  localparam int GP_RAD_W    = 10;

  // Coordinate arithmetic width (signed)
  localparam int CW = 12;

  // CE_arguments field positions
  localparam int ARG_XC_HI = 29;
  localparam int ARG_XC_LO = 20;
  localparam int ARG_YC_HI = 19;
  localparam int ARG_YC_LO = 10;
  localparam int ARG_R_HI  = 9;
  localparam int ARG_R_LO  = 0;

  // Frame base bits that land in the DRAM address
  localparam int FRAME_HI = 27;
  localparam int FRAME_LO = 22;

  typedef enum logic [2:0] {
    CE_IDLE  = 3'd0,
    CE_INIT  = 3'd1,
    CE_PIX   = 3'd2,
    CE_BURST = 3'd3,
    CE_STEP  = 3'd4
  } ce_state_t;

  typedef enum logic [1:0] {
    PW_IDLE  = 2'd0,
    PW_BEAT0 = 2'd1,
    PW_BEAT1 = 2'd2
  } pw_state_t;

  // Place a 32-bit pixel {8'h00, colour} into lane 0..3 of a 128-bit beat
  function automatic logic [127:0] beat_data(input logic [23:0] colour,
                                             input logic [1:0]  lane);
    beat_data = {96'd0, 8'h00, colour} << {lane, 5'd0};
  endfunction

  // Byte mask with only the four bytes of the given lane enabled (0 = write)
  function automatic logic [15:0] beat_mask(input logic [1:0] lane);
    beat_mask = ~(16'h000F << {lane, 2'b00});
  endfunction

endpackage

// File: rtl/circle_engine_pixel_burst_writer.sv
// Writes one pixel into DRAM as a two-beat burst: packs the address,
// places the colour in the right lane and masks every other byte.
module pixel_burst_writer
  import gp_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [9:0]   x,
  input  logic [9:0]   y,
  input  logic [23:0]  colour,
  input  logic [5:0]   frame,
  input  logic         af_full,
  input  logic         wdf_full,
  output logic         af_wr_en,
  output logic [30:0]  af_addr_din,
  output logic         wdf_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din,
  output logic         done
);

  pw_state_t  state;
  logic [1:0] lane;
  logic       upper;

  // x[2] picks the beat holding the pixel, x[1:0] the lane within it
  assign lane  = x[1:0];
  assign upper = x[2];

  // Burst handshake; a go that finds both FIFOs ready pushes beat 0 at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= PW_IDLE;
      af_wr_en     <= 1'b0;
      af_addr_din  <= 31'd0;
      wdf_wr_en    <= 1'b0;
      wdf_din      <= 128'd0;
      wdf_mask_din <= 16'hFFFF;
      done         <= 1'b0;
    end else begin
      af_wr_en  <= 1'b0;
      wdf_wr_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        PW_IDLE, PW_BEAT0: begin
          if ((state == PW_BEAT0) || go) begin
            if (!af_full && !wdf_full) begin
              af_wr_en     <= 1'b1;
              wdf_wr_en    <= 1'b1;
              af_addr_din  <= {6'd0, frame, y, x[9:3], 2'b00};
              wdf_din      <= upper ? 128'd0 : beat_data(colour, lane);
              wdf_mask_din <= upper ? 16'hFFFF : beat_mask(lane);
              state        <= PW_BEAT1;
            end else begin
              state <= PW_BEAT0;
            end
          end
        end
        PW_BEAT1: begin
          if (!wdf_full) begin
            wdf_wr_en    <= 1'b1;
            wdf_din      <= upper ? beat_data(colour, lane) : 128'd0;
            wdf_mask_din <= upper ? beat_mask(lane) : 16'hFFFF;
            done         <= 1'b1;
            state        <= PW_IDLE;
          end
        end
        default: state <= PW_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/circle_engine.sv
// Circle engine: latches colour and centre/radius, walks the midpoint
// circle one octant point at a time and hands on-screen pixels to the
// burst writer.
module circle_engine
  import gp_pkg::*;
#(
  parameter int SCREEN_W = GP_SCREEN_W,
  parameter int SCREEN_H = GP_SCREEN_H,
  parameter int RAD_W    = GP_RAD_W
) (
  input  logic         clk,
  input  logic         rst,
  output logic         CE_ready,
  input  logic [23:0]  CE_color,
  input  logic         CE_color_valid,
  input  logic [31:0]  CE_arguments,
  input  logic         CE_arguments_valid,
  input  logic         CE_trigger,
  input  logic [31:0]  CE_frame,
  input  logic         af_full,
  input  logic         wdf_full,
  output logic         af_wr_en,
  output logic [30:0]  af_addr_din,
  output logic         wdf_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din
);

  localparam logic signed [CW-1:0] SCR_W = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] SCR_H = CW'(SCREEN_H);

  ce_state_t                state;
  logic [23:0]              colour;
  logic [3*RAD_W-1:0]       args;
  logic signed [CW-1:0]     xc, yc, r;
  logic signed [CW-1:0]     px, py, d;
  logic signed [CW-1:0]     px_n, py_n, d_n;
  logic signed [CW-1:0]     pt_x, pt_y;
  logic [2:0]               k;
  logic                     on_screen;
  logic                     go;
  logic                     done;
  logic                     unused_bits;

  assign xc = $signed({{(CW-RAD_W){1'b0}}, args[3*RAD_W-1 -: RAD_W]});
  assign yc = $signed({{(CW-RAD_W){1'b0}}, args[2*RAD_W-1 -: RAD_W]});
  assign r  = $signed({{(CW-RAD_W){1'b0}}, args[RAD_W-1 -: RAD_W]});

  assign unused_bits = ^{CE_arguments[31:3*RAD_W], CE_frame[31:FRAME_HI+1],
                         CE_frame[FRAME_LO-1:0]};

  // Select the k-th of the eight symmetric points for the current (px, py)
  always_comb begin
    pt_x = xc;
    pt_y = yc;
    case (k)
      3'd0:    begin pt_x = xc + px; pt_y = yc + py; end
      3'd1:    begin pt_x = xc - px; pt_y = yc + py; end
      3'd2:    begin pt_x = xc + px; pt_y = yc - py; end
      3'd3:    begin pt_x = xc - px; pt_y = yc - py; end
      3'd4:    begin pt_x = xc + py; pt_y = yc + px; end
      3'd5:    begin pt_x = xc - py; pt_y = yc + px; end
      3'd6:    begin pt_x = xc + py; pt_y = yc - px; end
      3'd7:    begin pt_x = xc - py; pt_y = yc - px; end
      default: begin pt_x = xc;      pt_y = yc;      end
    endcase
  end

  assign on_screen = !pt_x[CW-1] && !pt_y[CW-1] && (pt_x < SCR_W) && (pt_y < SCR_H);
  assign go        = (state == CE_PIX) && on_screen;

  // Midpoint decision update; the new px/py feed the new decision value
  always_comb begin
    px_n = px + 12'sd1;
    if (d < 12'sd0) begin
      py_n = py;
      d_n  = d + (px_n <<< 1) + 12'sd1;
    end else begin
      py_n = py - 12'sd1;
      d_n  = d + ((px_n - py_n) <<< 1) + 12'sd1;
    end
  end

  // Main sequencer: start handling, octant walk, burst wait, midpoint step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CE_IDLE;
      CE_ready <= 1'b1;
      colour   <= 24'd0;
      args     <= '0;
      px       <= 12'sd0;
      py       <= 12'sd0;
      d        <= 12'sd0;
      k        <= 3'd0;
    end else begin
      case (state)
        CE_IDLE: begin
          if (CE_color_valid) begin
            colour <= CE_color;
          end
          if (CE_arguments_valid) begin
            args     <= CE_arguments[3*RAD_W-1:0];
            state    <= CE_INIT;
            CE_ready <= 1'b0;
          end else if (CE_trigger) begin
            state    <= CE_INIT;
            CE_ready <= 1'b0;
          end
        end
        CE_INIT: begin
          px    <= 12'sd0;
          py    <= r;
          d     <= 12'sd1 - r;
          k     <= 3'd0;
          state <= CE_PIX;
        end
        CE_PIX: begin
          if (on_screen) begin
            state <= CE_BURST;
          end else begin
            k     <= k + 3'd1;
            state <= (k == 3'd7) ? CE_STEP : CE_PIX;
          end
        end
        CE_BURST: begin
          if (done) begin
            k     <= k + 3'd1;
            state <= (k == 3'd7) ? CE_STEP : CE_PIX;
          end
        end
        CE_STEP: begin
          px <= px_n;
          py <= py_n;
          d  <= d_n;
          k  <= 3'd0;
          if (px_n > py_n) begin
            state    <= CE_IDLE;
            CE_ready <= 1'b1;
          end else begin
            state <= CE_PIX;
          end
        end
        default: begin
          state    <= CE_IDLE;
          CE_ready <= 1'b1;
        end
      endcase
    end
  end

  pixel_burst_writer u_writer (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .x            (pt_x[9:0]),
    .y            (pt_y[9:0]),
    .colour       (colour),
    .frame        (CE_frame[FRAME_HI:FRAME_LO]),
    .af_full      (af_full),
    .wdf_full     (wdf_full),
    .af_wr_en     (af_wr_en),
    .af_addr_din  (af_addr_din),
    .wdf_wr_en    (wdf_wr_en),
    .wdf_din      (wdf_din),
    .wdf_mask_din (wdf_mask_din),
    .done         (done)
  );

endmodule

// File: tb/tb_circle_engine.sv
// Bench for circle_engine: an integer midpoint model predicts every
// burst beat; a negedge process compares each push against it.
module tb_circle_engine;

  logic         clk;
  logic         rst;
  logic         CE_ready;
  logic [23:0]  CE_color;
  logic         CE_color_valid;
  logic [31:0]  CE_arguments;
  logic         CE_arguments_valid;
  logic         CE_trigger;
  logic [31:0]  CE_frame;
  logic         af_full;
  logic         wdf_full;
  logic         af_wr_en;
  logic [30:0]  af_addr_din;
  logic         wdf_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;

  circle_engine dut (
    .clk                (clk),
    .rst                (rst),
    .CE_ready           (CE_ready),
    .CE_color           (CE_color),
    .CE_color_valid     (CE_color_valid),
    .CE_arguments       (CE_arguments),
    .CE_arguments_valid (CE_arguments_valid),
    .CE_trigger         (CE_trigger),
    .CE_frame           (CE_frame),
    .af_full            (af_full),
    .wdf_full           (wdf_full),
    .af_wr_en           (af_wr_en),
    .af_addr_din        (af_addr_din),
    .wdf_wr_en          (wdf_wr_en),
    .wdf_din            (wdf_din),
    .wdf_mask_din       (wdf_mask_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           first;
    logic [30:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
  } beat_t;

  beat_t exp_q[$];
  int    pix_q[$];
  int    total = 0;
  int    bad   = 0;
  int    n_af  = 0;
  logic [30:0]  last_addr;
  logic [15:0]  last_b0_mask;
  logic [127:0] last_b1_data;
  logic [15:0]  last_b1_mask;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected two beats for one pixel, built byte by byte
  task automatic add_pixel(input logic [23:0] col, input int x, input int y);
    beat_t       e;
    logic [31:0] word;
    int          lane;
    int          ff;
    word = {8'h00, col};
    lane = x % 8;
    ff   = (CE_frame >> 22) & 63;
    for (int b = 0; b < 2; b++) begin
      e.first = (b == 0);
      e.addr  = 31'(ff * 524288 + y * 512 + (x / 8) * 4);
      e.data  = '0;
      e.mask  = 16'hFFFF;
      if (lane / 4 == b) begin
        for (int j = 0; j < 16; j++) begin
          if (j / 4 == lane % 4) begin
            e.mask[j]       = 1'b0;
            e.data[8*j +: 8] = word[8*(j%4) +: 8];
          end
        end
      end
      exp_q.push_back(e);
    end
  endtask

  // Reference midpoint circle: queues every on-screen point in octant order
  task automatic model_circle(input logic [23:0] col, input int xc, input int yc,
                              input int r, output int n);
    int px, py, d, x, y;
    int ox[8];
    int oy[8];
    px = 0; py = r; d = 1 - r; n = 0;
    pix_q.delete();
    do begin
      ox = '{px, -px, px, -px, py, -py, py, -py};
      oy = '{py, py, -py, -py, px, px, -px, -px};
      for (int k = 0; k < 8; k++) begin
        x = xc + ox[k];
        y = yc + oy[k];
        if (x >= 0 && x < 800 && y >= 0 && y < 600) begin
          add_pixel(col, x, y);
          pix_q.push_back(x * 1000 + y);
          n++;
        end
      end
      px++;
      if (d < 0) d += 2 * px + 1;
      else begin
        py--;
        d += 2 * (px - py) + 1;
      end
    end while (px <= py);
  endtask

  function automatic bit has_pix(input int x, input int y);
    has_pix = 1'b0;
    foreach (pix_q[i]) if (pix_q[i] == x * 1000 + y) has_pix = 1'b1;
  endfunction

  // Compare every FIFO push against the model queue
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (af_wr_en && !wdf_wr_en) check("af_without_wdf", 1, 0);
      if (wdf_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_push", wdf_din, 0);
        end else begin
          e = exp_q.pop_front();
          check("push_kind", af_wr_en, e.first);
          if (e.first) check("addr", af_addr_din, e.addr);
          check("data", wdf_din, e.data);
          check("mask", wdf_mask_din, e.mask);
        end
        if (af_wr_en) begin
          n_af++;
          last_addr    = af_addr_din;
          last_b0_mask = wdf_mask_din;
        end else begin
          last_b1_data = wdf_din;
          last_b1_mask = wdf_mask_din;
        end
      end
    end
  end

  task automatic start(input logic [23:0] col, input int xc, input int yc, input int r);
    @(posedge clk); #1;
    CE_color           = col;
    CE_color_valid     = 1'b1;
    CE_arguments       = {2'b11, 10'(xc), 10'(yc), 10'(r)};
    CE_arguments_valid = 1'b1;
    @(posedge clk); #1;
    CE_color_valid     = 1'b0;
    CE_arguments_valid = 1'b0;
    check("ready_low_after_start", CE_ready, 0);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!CE_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready_timeout"}, (n < 3000), 1);
    @(negedge clk);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int held;
    int cnt;
    rst = 1'b1;
    CE_color = 24'd0; CE_color_valid = 1'b0;
    CE_arguments = 32'd0; CE_arguments_valid = 1'b0; CE_trigger = 1'b0;
    CE_frame = 32'h0AC0_0000;
    af_full = 1'b0; wdf_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", CE_ready, 1);
    check("rst_af_wr_en", af_wr_en, 0);
    check("rst_wdf_wr_en", wdf_wr_en, 0);
    check("rst_addr", af_addr_din, 0);
    check("rst_din", wdf_din, 0);
    check("rst_mask", wdf_mask_din, 16'hFFFF);

    // r = 0: eight writes of the centre pixel
    model_circle(24'h00FF00, 100, 100, 0, n);
    check("model_r0_count", n, 8);
    check("model_r0_addr", exp_q[0].addr, {6'b0, 6'h2B, 10'd100, 7'd12, 2'b00});
    n_af = 0;
    start(24'h00FF00, 100, 100, 0);
    wait_ready("r0");
    check("r0_af_pushes", n_af, 8);
    check("r0_addr_literal", last_addr, {6'b0, 6'h2B, 10'd100, 7'd12, 2'b00});
    check("r0_beat0_mask", last_b0_mask, 16'hFFFF);
    check("r0_beat1_mask", last_b1_mask, 16'hFFF0);
    check("r0_beat1_pixel", last_b1_data[31:0], 32'h0000FF00);

    // r = 3 around the screen centre
    model_circle(24'h123456, 400, 300, 3, n);
    check("model_r3_count", n, 24);
    check("model_r3_p0", has_pix(403, 300), 1);
    check("model_r3_p1", has_pix(400, 303), 1);
    check("model_r3_p2", has_pix(397, 300), 1);
    check("model_r3_p3", has_pix(400, 297), 1);
    n_af = 0;
    start(24'h123456, 400, 300, 3);
    wait_ready("r3");
    check("r3_af_pushes", n_af, 24);

    // Origin: only the x >= 0, y >= 0 quadrant survives
    model_circle(24'hABCDEF, 0, 0, 5, n);
    check("model_origin_count", n, 10);
    n_af = 0;
    start(24'hABCDEF, 0, 0, 5);
    wait_ready("origin");
    check("origin_af_pushes", n_af, 10);

    // Bottom-right corner: x >= 800 and y >= 600 clipped
    model_circle(24'h0000FF, 799, 599, 1, n);
    check("model_corner_count", n, 4);
    n_af = 0;
    start(24'h0000FF, 799, 599, 1);
    wait_ready("corner");
    check("corner_af_pushes", n_af, 4);

    // Address FIFO full held for 20 cycles while the first burst waits
    model_circle(24'h777777, 50, 60, 0, n);
    n_af = 0;
    af_full = 1'b1;
    start(24'h777777, 50, 60, 0);
    held = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (af_wr_en || wdf_wr_en) held++;
    end
    check("held_no_push", held, 0);
    @(posedge clk); #1 af_full = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("push_after_release", af_wr_en, 1);
    wait_ready("backpressure");
    check("backpressure_af_pushes", n_af, 8);

    // Start inputs during a draw are ignored; trigger later redraws circle A
    model_circle(24'h123456, 400, 300, 3, n);
    start(24'h123456, 400, 300, 3);
    repeat (5) @(posedge clk);
    #1;
    CE_color = 24'hFF0000; CE_color_valid = 1'b1;
    CE_arguments = {2'b00, 10'd10, 10'd10, 10'd2}; CE_arguments_valid = 1'b1;
    CE_trigger = 1'b1;
    @(posedge clk); #1;
    CE_color_valid = 1'b0; CE_arguments_valid = 1'b0; CE_trigger = 1'b0;
    wait_ready("middraw");
    model_circle(24'h123456, 400, 300, 3, n);
    n_af = 0;
    @(posedge clk); #1 CE_trigger = 1'b1;
    @(posedge clk); #1 CE_trigger = 1'b0;
    check("trigger_ready_low", CE_ready, 0);
    wait_ready("redraw");
    check("redraw_af_pushes", n_af, 24);

    // Asynchronous reset while the writer is between beat 0 and beat 1
    model_circle(24'h010203, 400, 300, 3, n);
    start(24'h010203, 400, 300, 3);
    cnt = 0;
    while (!af_wr_en && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("beat0_seen", af_wr_en, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_wdf_wr_en", wdf_wr_en, 0);
    check("async_rst_af_wr_en", af_wr_en, 0);
    check("async_rst_mask", wdf_mask_din, 16'hFFFF);
    check("async_rst_din", wdf_din, 0);
    check("async_rst_addr", af_addr_din, 0);
    check("async_rst_ready", CE_ready, 1);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", CE_ready, 1);

    // Engine works normally after the abort
    model_circle(24'h445566, 200, 150, 2, n);
    start(24'h445566, 200, 150, 2);
    wait_ready("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
